// File: rtl/ad9959_pkg.sv
// Shared AD9959 serial-port definitions.
// Used by the command serializer and the readback receiver.
package ad9959_pkg;

  localparam logic SPI_SGL = 1'b0;
  localparam logic SPI_MUL = 1'b1;

  localparam logic [4:0] CSR  = 5'd0;
  localparam logic [4:0] FR1  = 5'd1;
  localparam logic [4:0] FR2  = 5'd2;
  localparam logic [4:0] CFR  = 5'd3;
  localparam logic [4:0] CFTW = 5'd4;
  localparam logic [4:0] CPOW = 5'd5;
  localparam logic [4:0] ACR  = 5'd6;
  localparam logic [4:0] LSRR = 5'd7;

  typedef enum logic [1:0] {
    RB_IDLE,
    RB_INSTR,
    RB_CAPT,
    RB_DONE
  } rb_state_e;

  // Register width in bytes; channel words above LSRR are 32-bit.
  function automatic logic [2:0] reg_bytes(input logic [4:0] addr);
    logic [2:0] n;
    unique case (addr)
      CSR:     n = 3'd1;
      FR1:     n = 3'd3;
      FR2:     n = 3'd2;
      CFR:     n = 3'd3;
      CFTW:    n = 3'd4;
      CPOW:    n = 3'd2;
      ACR:     n = 3'd3;
      LSRR:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ad9959_shift_in.sv
// 32-bit clearable left shifter, 1-bit or 4-bit input.
// d_o exposes the next value so a final sample can be used at once.
module ad9959_shift_in (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        quad_i,
  input  logic [3:0]  din_i,
  output logic [31:0] d_o
);

  logic [31:0] shift_q;
  logic [31:0] shift_d;

  // Next value: clear wins, else shift by 1 or 4 bits.
  always_comb begin
    shift_d = shift_q;
    if (clr_i) begin
      shift_d = '0;
    end else if (en_i) begin
      if (quad_i) begin
        shift_d = {shift_q[27:0], din_i};
      end else begin
        shift_d = {shift_q[30:0], din_i[0]};
      end
    end
  end

  // Shift register state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign d_o = shift_d;

endmodule

// File: rtl/ad9959_readback.sv
// AD9959 SDIO read-data receiver.
// Skips instruction slots, then captures a right-aligned register word.
module ad9959_readback
  import ad9959_pkg::*;
#(
  parameter int READ_PIN   = 2,
  parameter int INSTR_SGL  = 8,
  parameter int INSTR_QUAD = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [4:0]  addr_i,
  input  logic        mode_i,
  input  logic        csb_i,
  input  logic [3:0]  sdio_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        abort_o
);

  localparam logic [5:0] ISGL_LAST  = 6'(INSTR_SGL - 1);
  localparam logic [5:0] IQUAD_LAST = 6'(INSTR_QUAD - 1);

  rb_state_e   state_q;
  logic [4:0]  addr_q;
  logic        mode_q;
  logic [5:0]  cnt_q;
  logic [31:0] data_q;
  logic        valid_q;
  logic        busy_q;
  logic        abort_q;

  logic [2:0]  nbytes;
  logic [5:0]  cap_last;
  logic [5:0]  ins_last;
  logic        sh_clr;
  logic        sh_en;
  logic [3:0]  sh_din;
  logic [31:0] sh_next;

  // Slot counts and shifter controls for the current read.
  always_comb begin
    nbytes   = reg_bytes(addr_q);
    cap_last = (mode_q == SPI_MUL) ? ({2'b0, nbytes, 1'b0} - 6'd1)
                                   : ({nbytes, 3'b0} - 6'd1);
    ins_last = (mode_q == SPI_MUL) ? IQUAD_LAST : ISGL_LAST;
    sh_clr   = (state_q == RB_IDLE) && start_i;
    sh_en    = (state_q == RB_CAPT) && !csb_i;
    sh_din   = (mode_q == SPI_MUL) ? sdio_i : {4{sdio_i[READ_PIN]}};
  end

  ad9959_shift_in u_shift (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (sh_clr),
    .en_i    (sh_en),
    .quad_i  (mode_q),
    .din_i   (sh_din),
    .d_o     (sh_next)
  );

  // Read sequencer with registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RB_IDLE;
      addr_q  <= '0;
      mode_q  <= SPI_SGL;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      unique case (state_q)
        RB_IDLE: begin
          if (start_i) begin
            addr_q  <= addr_i;
            mode_q  <= mode_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RB_INSTR;
          end
        end
        RB_INSTR: begin
          if (csb_i) begin
            abort_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= RB_IDLE;
          end else if (cnt_q == ins_last) begin
            cnt_q   <= '0;
            state_q <= RB_CAPT;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        RB_CAPT: begin
          if (csb_i) begin
            abort_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= RB_IDLE;
          end else if (cnt_q == cap_last) begin
            data_q  <= sh_next;
            valid_q <= 1'b1;
            state_q <= RB_DONE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        RB_DONE: begin
          busy_q  <= 1'b0;
          state_q <= RB_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= RB_IDLE;
        end
      endcase
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign abort_o = abort_q;

endmodule
